// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator for a Sobel core: two line buffers feed a
// 3x3 shift register, and a registered copy of each valid window drives the outputs.
module sobel_window_gen #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 32
) (
   input  logic                   clk_i,
   input  logic                   nreset_i,
   input  logic                   in_valid_i,
   input  logic [PIXEL_WIDTH-1:0] in_pixel_i,
   input  logic                   sof_i,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o0,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o1,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o2,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o3,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o4,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o5,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o6,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o7,
   output logic [PIXEL_WIDTH-1:0] matrix_pixels_o8,
   output logic                   window_valid_o,
   output logic                   frame_done_o
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

   typedef enum logic {FILL, ACTIVE} state_t;

   state_t                 state_reg;
   logic [COL_W-1:0]       col_reg;
   logic [ROW_W-1:0]       row_reg;
   logic                   valid_reg;
   logic                   done_reg;

   logic [PIXEL_WIDTH-1:0] lb_top [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] lb_mid [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] shift_reg  [9];
   logic [PIXEL_WIDTH-1:0] shift_next [9];
   logic [PIXEL_WIDTH-1:0] window_reg [9];
   logic [PIXEL_WIDTH-1:0] new_col    [3];

   logic                   restart;
   logic                   window_hit;
   logic [COL_W-1:0]       addr;

   // A start-of-frame pixel is always column 0, whatever the counters say.
   assign restart    = in_valid_i & sof_i;
   assign addr       = restart ? '0 : col_reg;
   assign window_hit = in_valid_i && !sof_i && (state_reg == ACTIVE) && (col_reg >= COL_TWO);

   // Buffers are read combinationally so the window is ready one edge after the pixel.
   assign new_col[0] = lb_top[addr];
   assign new_col[1] = lb_mid[addr];
   assign new_col[2] = in_pixel_i;

   for (genvar gi = 0; gi < 3; gi++) begin : g_shift
      assign shift_next[3*gi]     = shift_reg[3*gi+1];
      assign shift_next[3*gi + 1] = shift_reg[3*gi+2];
      assign shift_next[3*gi + 2] = new_col[gi];
   end

   always_ff @(posedge clk_i) begin
      if (in_valid_i) begin
         lb_top[addr] <= lb_mid[addr];
         lb_mid[addr] <= in_pixel_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_reg <= FILL;
         col_reg   <= '0;
         row_reg   <= '0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            shift_reg[i]  <= '0;
            window_reg[i] <= '0;
         end
      end else begin
         done_reg  <= 1'b0;
         valid_reg <= window_hit;
         if (window_hit) begin
            for (int i = 0; i < 9; i++) window_reg[i] <= shift_next[i];
         end
         if (in_valid_i) begin
            for (int i = 0; i < 9; i++) shift_reg[i] <= shift_next[i];
            if (sof_i) begin
               state_reg <= FILL;
               col_reg   <= COL_W'(1);
               row_reg   <= '0;
            end else if (col_reg == COL_LAST) begin
               col_reg <= '0;
               if (row_reg == ROW_LAST) begin
                  row_reg   <= '0;
                  state_reg <= FILL;
                  done_reg  <= 1'b1;
               end else begin
                  row_reg <= row_reg + ROW_W'(1);
                  if (row_reg == ROW_ONE) state_reg <= ACTIVE;
               end
            end else begin
               col_reg <= col_reg + COL_W'(1);
            end
         end
      end
   end

   assign matrix_pixels_o0 = window_reg[0];
   assign matrix_pixels_o1 = window_reg[1];
   assign matrix_pixels_o2 = window_reg[2];
   assign matrix_pixels_o3 = window_reg[3];
   assign matrix_pixels_o4 = window_reg[4];
   assign matrix_pixels_o5 = window_reg[5];
   assign matrix_pixels_o6 = window_reg[6];
   assign matrix_pixels_o7 = window_reg[7];
   assign matrix_pixels_o8 = window_reg[8];
   assign window_valid_o   = valid_reg;
   assign frame_done_o     = done_reg;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image with pixel = row*4+col (+ base).
module tb_sobel_window_gen;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_pixel = '0;
   logic       sof = 1'b0;
   logic [7:0] o0, o1, o2, o3, o4, o5, o6, o7, o8;
   logic       window_valid, frame_done;

   int tests_run = 0;
   int tests_failed = 0;

   sobel_window_gen #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
      .clk_i(clk), .nreset_i(nreset), .in_valid_i(in_valid), .in_pixel_i(in_pixel), .sof_i(sof),
      .matrix_pixels_o0(o0), .matrix_pixels_o1(o1), .matrix_pixels_o2(o2),
      .matrix_pixels_o3(o3), .matrix_pixels_o4(o4), .matrix_pixels_o5(o5),
      .matrix_pixels_o6(o6), .matrix_pixels_o7(o7), .matrix_pixels_o8(o8),
      .window_valid_o(window_valid), .frame_done_o(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [71:0] cur_win();
      return {o0, o1, o2, o3, o4, o5, o6, o7, o8};
   endfunction

   // Window centred on pixel value v in a 4-wide raster.
   function automatic logic [71:0] exp_win(input int v);
      return {8'(v-5), 8'(v-4), 8'(v-3), 8'(v-1), 8'(v), 8'(v+1), 8'(v+3), 8'(v+4), 8'(v+5)};
   endfunction

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] p, input logic s);
      @(negedge clk);
      in_valid = v;
      in_pixel = p;
      sof      = s;
      @(posedge clk);
      #1;
   endtask

   task automatic stream_frame(input int base, input bit gaps, input bit first_sof, input string name);
      int nwin;
      logic [71:0] last;
      logic exp_v;
      nwin = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(base + i), first_sof && (i == 0));
         exp_v = (i >= 8) && ((i % 4) >= 2);
         check($sformatf("%s px%0d valid", name, i), 72'(window_valid), 72'(exp_v));
         check($sformatf("%s px%0d done", name, i), 72'(frame_done), 72'(i == 15));
         if (window_valid) nwin++;
         if (exp_v) check($sformatf("%s px%0d window", name, i), cur_win(), exp_win(base + i - 5));
         last = cur_win();
         if (gaps) begin
            cyc(1'b0, 8'hAA, 1'b1);
            check($sformatf("%s gap%0d valid", name, i), 72'(window_valid), 72'(0));
            check($sformatf("%s gap%0d done", name, i), 72'(frame_done), 72'(0));
            check($sformatf("%s gap%0d hold", name, i), cur_win(), last);
         end
      end
      check($sformatf("%s window count", name), 72'(nwin), 72'(4));
   endtask

   initial begin
      // Reset state
      nreset = 1'b0;
      cyc(1'b1, 8'h55, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      check("reset valid", 72'(window_valid), 72'(0));
      check("reset done", 72'(frame_done), 72'(0));
      check("reset window", cur_win(), 72'(0));
      nreset = 1'b1;

      // First frame, back-to-back; then explicit first/last window constants
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         if (i == 9) check("f1 before px10 valid", 72'(window_valid), 72'(0));
         if (i == 10) begin
            check("f1 first valid", 72'(window_valid), 72'(1));
            check("f1 first window", cur_win(),
                  {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
         end
         if (i == 11) check("f1 centre6", 72'(o4), 72'(6));
         if (i == 14) check("f1 centre9", 72'(o4), 72'(9));
         if (i == 15) begin
            check("f1 last window", cur_win(),
                  {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15});
            check("f1 done pulse", 72'(frame_done), 72'(1));
         end
      end

      // Second frame immediately after, values +100
      stream_frame(100, 1'b0, 1'b0, "f2");
      cyc(1'b0, 8'h00, 1'b0);
      check("f2 done single", 72'(frame_done), 72'(0));
      check("f2 hold last", cur_win(), exp_win(110));

      // Gapped frame, with sof toggled during gaps (must be ignored)
      stream_frame(0, 1'b1, 1'b0, "gap");

      // Abort at pixel 6 with sof, then a fresh frame
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 8'(200 + i), 1'b0);
         check($sformatf("abort6 px%0d done", i), 72'(frame_done), 72'(0));
      end
      stream_frame(0, 1'b0, 1'b1, "sof6");

      // Abort at pixel 12 (state already active), then a fresh frame
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 8'(50 + i), 1'b0);
         check($sformatf("abort12 px%0d done", i), 72'(frame_done), 72'(0));
      end
      check("abort12 last window", cur_win(), exp_win(56));
      stream_frame(0, 1'b0, 1'b1, "sof12");

      // Reset mid-frame after pixel 9, then restart without sof
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(30 + i), 1'b0);
      nreset = 1'b0;
      cyc(1'b0, 8'h00, 1'b0);
      check("midrst valid", 72'(window_valid), 72'(0));
      check("midrst done", 72'(frame_done), 72'(0));
      check("midrst window", cur_win(), 72'(0));
      nreset = 1'b1;
      stream_frame(0, 1'b0, 1'b0, "rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
